// File: rtl/mant_mul_seq.sv
// mant_mul_seq: sequential 24x24 significand multiplier for an IEEE-754
// single-precision multiply front end. Operands are unpacked at acceptance,
// the exponent sum, sign and special-case flags are latched, and the
// significand product is accumulated by shift-add over the multiplier.
//
// Build option: define MUL_RADIX4_EN to retire two multiplier bits per CALC
// cycle (12 cycles) instead of one (24 cycles). P is identical in both builds.

module mant_mul_seq #(
    parameter int BIAS = 127
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [47:0] P,
    output logic [9:0]  Ez_add,
    output logic        sign_z,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        out_valid,
    input  logic        out_ready
);

`ifdef MUL_RADIX4_EN
    localparam int STEPS = 12;
    localparam int SHIFT = 2;
`else
    localparam int STEPS = 24;
    localparam int SHIFT = 1;
`endif

    localparam logic [4:0] LAST_ITER = 5'(STEPS - 1);
    localparam logic [9:0] BIAS_W    = 10'(BIAS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [47:0] mcand;     // multiplicand, shifted left as bits are retired
    logic [23:0] mplier;    // multiplier, shifted right as bits are retired
    logic [4:0]  iter;      // CALC steps completed so far
    logic [47:0] step_add;  // partial product added this CALC cycle

    // Field extraction of both operands.
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;

    assign {sa, ea, ma} = A;
    assign {sb, eb, mb} = B;

    // Denormals and zero use an implicit 0 and an effective exponent of 1.
    logic [23:0] sig_a, sig_b;
    logic [7:0]  exp_a, exp_b;

    assign sig_a = {(ea != 8'd0), ma};
    assign sig_b = {(eb != 8'd0), mb};
    assign exp_a = (ea == 8'd0) ? 8'd1 : ea;
    assign exp_b = (eb == 8'd0) ? 8'd1 : eb;

    // Operand classification.
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic nan_in, inf_in, zero_in;

    assign zero_a = (ea == 8'd0)   && (ma == 23'd0);
    assign zero_b = (eb == 8'd0)   && (mb == 23'd0);
    assign inf_a  = (ea == 8'hFF) && (ma == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (mb == 23'd0);
    assign nan_a  = (ea == 8'hFF) && (ma != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (mb != 23'd0);

    assign nan_in  = nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b);
    assign inf_in  = (inf_a || inf_b) && !nan_in;
    assign zero_in = (zero_a || zero_b) && !nan_in;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Partial product for the multiplier bit(s) retired this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (which would infer a latch).
        step_add = 48'd0;
        if (mplier[0]) step_add = mcand;
`ifdef MUL_RADIX4_EN
        if (mplier[1]) step_add = step_add + (mcand << 1);
`endif
    end

    // Next-state logic for the IDLE -> CALC -> DONE handshake sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)          state_nxt = CALC;
            CALC:    if (iter == LAST_ITER) state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Datapath: latch operands at acceptance, shift-add during CALC, hold in DONE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand   <= 48'd0;
            mplier  <= 24'd0;
            iter    <= 5'd0;
            P       <= 48'd0;
            Ez_add  <= 10'd0;
            sign_z  <= 1'b0;
            is_zero <= 1'b0;
            is_inf  <= 1'b0;
            is_nan  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand   <= {24'd0, sig_a};
                        mplier  <= sig_b;
                        iter    <= 5'd0;
                        P       <= 48'd0;
                        Ez_add  <= {2'b00, exp_a} + {2'b00, exp_b} - BIAS_W;
                        sign_z  <= sa ^ sb;
                        is_zero <= zero_in;
                        is_inf  <= inf_in;
                        is_nan  <= nan_in;
                    end
                end
                CALC: begin
                    P      <= P + step_add;
                    mcand  <= mcand << SHIFT;
                    mplier <= mplier >> SHIFT;
                    iter   <= iter + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mul_seq.sv
// tb_mant_mul_seq: scoreboard bench for mant_mul_seq. The driver pushes the
// expected result of every accepted operand pair; an independent monitor
// pops and compares whenever the DUT presents a result. The reference model
// is plain arithmetic on the IEEE-754 fields.

module tb_mant_mul_seq;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 24;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] P;
    logic [9:0]  Ez_add;
    logic        sign_z, is_zero, is_inf, is_nan, out_valid;
    logic        out_ready = 1'b0;

    mant_mul_seq #(.BIAS(127)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .P(P), .Ez_add(Ez_add), .sign_z(sign_z), .is_zero(is_zero), .is_inf(is_inf),
        .is_nan(is_nan), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [47:0] p;
        logic [9:0]  ez;
        logic        s;
        logic        z;
        logic        i;
        logic        n;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic hold_ready = 1'b0;
    logic seen = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the floating-point field rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   ea, eb, ef_a, ef_b;
        longint unsigned ma, mb, siga, sigb;
        bit   za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        ma = longint'(a[22:0]); mb = longint'(b[22:0]);
        siga = (ea == 0) ? ma : ma + (64'd1 << 23);
        sigb = (eb == 0) ? mb : mb + (64'd1 << 23);
        ef_a = (ea == 0) ? 1 : ea;
        ef_b = (eb == 0) ? 1 : eb;
        za = (ea == 0) && (ma == 0);   zb = (eb == 0) && (mb == 0);
        ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
        na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
        e.p  = 48'(siga * sigb);
        e.ez = 10'(ef_a + ef_b - 127);
        e.s  = a[31] ^ b[31];
        e.n  = na || nb || (ia && zb) || (za && ib);
        e.i  = (ia || ib) && !e.n;
        e.z  = (za || zb) && !e.n;
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [47:0] p, input logic [9:0] ez, input logic s,
                                input logic z, input logic i, input logic n);
        exp_t e;
        e.p = p; e.ez = ez; e.s = s; e.z = z; e.i = i; e.n = n; e.acc = 0;
        return e;
    endfunction

    // Monitor: compare the presented result against the scoreboard head.
    always @(negedge CLK) begin
        if (RST && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
                out_ready = 1'b1;
            end else begin
                exp_t e;
                e = sb[0];
                if (!seen) begin
                    check("latency", 64'(cyc - e.acc), 64'(LAT));
                    seen = 1'b1;
                end
                if (!(e.z || e.i || e.n)) check("P", 64'(P), 64'(e.p));
                check("Ez_add", 64'(Ez_add), 64'(e.ez));
                check("sign_z", 64'(sign_z), 64'(e.s));
                check("flags_zin", 64'({is_zero, is_inf, is_nan}), 64'({e.z, e.i, e.n}));
                out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end else begin
            out_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Present an operand pair, wait for acceptance, record the expectation.
    // Leaves in_valid high with junk operands that must be ignored in CALC.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n = 0;
        @(negedge CLK);
        A = a; B = b; in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        A = $urandom; B = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    initial begin
        logic [47:0] p0;
        logic [9:0]  ez0;
        logic [4:0]  f0;
        int          n;
        int          vcount;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_P", 64'(P), 64'd0);
        check("rst_misc", 64'({Ez_add, sign_z, is_zero, is_inf, is_nan, out_valid}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases with spec-derived constants.
        issue(32'h3F800000, 32'h3F800000, mk(48'h400000000000, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h3FC00000, 32'h3FC00000, mk(48'h900000000000, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h0D800000, 32'h8D800000, mk(48'h400000000000, 10'h3B7, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(32'h00000001, 32'h3F800000, mk(48'h000000800000, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // inf * 0 with the downstream stalled for 5 cycles.
        hold_ready = 1'b1;
        issue(32'h7F800000, 32'h00000000, mk(48'h0, 10'h081, 1'b0, 1'b0, 1'b0, 1'b1));
        in_valid = 1'b1;  // operands presented during DONE must not be taken
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("stall_out_valid", 64'(out_valid), 64'd1);
        p0 = P; ez0 = Ez_add; f0 = {sign_z, is_zero, is_inf, is_nan, out_valid};
        repeat (5) begin
            @(negedge CLK);
            check("stall_P", 64'(P), 64'(p0));
            check("stall_fields", 64'({Ez_add, sign_z, is_zero, is_inf, is_nan, out_valid}),
                  64'({ez0, f0}));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        hold_ready = 1'b0;
        drain();

        // Randomized operands, including zeros, denormals, infinities and NaNs.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            a = rand_fp();
            b = rand_fp();
            issue(a, b, model(a, b));
        end
        drain();

        // Reset pulsed in the middle of CALC.
        @(negedge CLK);
        A = 32'h3FC00000; B = 32'h3FC00000; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_P", 64'(P), 64'd0);
        check("midrst_misc", 64'({Ez_add, sign_z, is_zero, is_inf, is_nan, out_valid}), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);
        RST = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge CLK);
            if (out_valid) vcount++;
        end
        check("no_result_after_reset", 64'(vcount), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
